sn74ls374: RTL and testbench



---
 rtl/sn74ls374_pkg.sv | 10 +
 rtl/sn74ls374_tristate_buf.sv | 24 ++
 rtl/sn74ls374.sv | 47 ++++
 tb/tb_sn74ls374.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sn74ls374_pkg.sv
// -----------------------------------------------------------------------------
// sn74ls374_pkg
//   Shared constants for the ISA/CAMAC interface board bus logic.
//   DEFAULT_BUS_WIDTH : width of one byte lane on the board's shared buses.
// -----------------------------------------------------------------------------
package sn74ls374_pkg;

  localparam int DEFAULT_BUS_WIDTH = 8;

endpackage : sn74ls374_pkg

// File: rtl/sn74ls374_tristate_buf.sv
// -----------------------------------------------------------------------------
// tristate_buf
//   WIDTH-bit 3-state bus driver with an active-low enable. This block is
//   shared by every driver that sits on the board's common buses.
//
// Ports
//   data  : value to drive when enabled
//   oe_n  : active-low output enable (0 = drive, 1 = high-Z)
//   out   : 3-state output bus
// -----------------------------------------------------------------------------
module tristate_buf
  import sn74ls374_pkg::*;
#(
  parameter int WIDTH = DEFAULT_BUS_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             oe_n,
  output logic [WIDTH-1:0] out
);

  // Purely combinational, so an enable change reaches the bus with no clocking.
  assign out = oe_n ? {WIDTH{1'bz}} : data;

endmodule : tristate_buf

// File: rtl/sn74ls374.sv
// -----------------------------------------------------------------------------
// sn74ls374
//   Octal edge-triggered D register with 3-state outputs (74LS374 equivalent).
//   Used as a bus-holding latch toward a shared 3-state bus.
//
// Ports
//   clk         : capture clock, data sampled on the rising edge
//   rst_n       : asynchronous active-low reset, clears the stored value
//   data        : parallel data to capture
//   out_control : active-low output enable (/OE): 0 = driven, 1 = high-Z
//   out         : 3-state output bus
// -----------------------------------------------------------------------------
module sn74ls374
  import sn74ls374_pkg::*;
#(
  parameter int WIDTH = DEFAULT_BUS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             out_control,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] q;

  // Capture stage: every rising edge loads, there is no clock enable. The
  // register keeps loading while the outputs are floated, so re-enabling
  // always presents the latest capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= data;
    end
  end

  // Output stage: enable path is independent of the clock.
  tristate_buf #(
    .WIDTH (WIDTH)
  ) u_out_buf (
    .data (q),
    .oe_n (out_control),
    .out  (out)
  );

endmodule : sn74ls374

// File: tb/tb_sn74ls374.sv
module tb_sn74ls374;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         out_control = 1'b1;
  logic [W-1:0] data = '0;

  // Shared bus with a bench-side driver used to probe for high-Z: if the DUT
  // is really floating, the bus follows whatever the bench drives.
  wire  [W-1:0] bus;
  logic         tb_drv_en = 1'b0;
  logic [W-1:0] tb_drv_val = '0;
  assign bus = tb_drv_en ? tb_drv_val : {W{1'bz}};

  sn74ls374 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data        (data),
    .out_control (out_control),
    .out         (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the stored byte is simply "the data value present at the
  // most recent rising edge taken while not in reset, or zero since reset".
  logic [W-1:0] exp_q = '0;

  typedef struct {
    logic         rst_n;
    logic         oe_n;
    logic [W-1:0] data;
    logic         edge_en;
    logic         exp_drv;
    logic [W-1:0] exp_out;
  } vec_t;

  task automatic set_rst(input logic v);
    rst_n = v;
    if (!v) exp_q = '0;
  endtask

  task automatic rise();
    clk = 1'b1;
    if (rst_n) exp_q = data;
    #5;
    clk = 1'b0;
    #5;
  endtask

  task automatic check(input string name, input logic exp_drv, input logic [W-1:0] exp_val);
    logic ok;
    logic [W-1:0] got_a, got_b;
    #1;
    n_checks++;
    if (exp_drv) begin
      tb_drv_en = 1'b0;
      #1;
      got_a = bus;
      ok = (bus === exp_val);
      if (ok) n_pass++;
      else $display("FAIL %s: out=%h expected %h", name, got_a, exp_val);
    end else begin
      tb_drv_en  = 1'b1;
      tb_drv_val = 8'hA5;
      #1;
      got_a = bus;
      tb_drv_val = 8'h5A;
      #1;
      got_b = bus;
      tb_drv_en = 1'b0;
      #1;
      ok = (got_a === 8'hA5) && (got_b === 8'h5A);
      if (ok) n_pass++;
      else $display("FAIL %s: bus probes %h/%h expected a5/5a (out should be high-Z)",
                    name, got_a, got_b);
    end
  endtask

  vec_t vecs[$];

  initial begin
    // ---------------- reset held: edges ignored ----------------
    out_control = 1'b0;
    data = 8'hA5;
    set_rst(1'b0);
    #3;
    check("reset_initial", 1'b1, 8'h00);
    rise();
    check("reset_edge1", 1'b1, 8'h00);
    rise();
    check("reset_edge2", 1'b1, 8'h00);

    set_rst(1'b1);
    #2;

    // ---------------- table-driven vectors ----------------
    vecs.push_back('{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b1, 8'h02, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 8'h02});
    vecs.push_back('{1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h3C});
    vecs.push_back('{1'b1, 1'b0, 8'hC3, 1'b0, 1'b1, 8'h3C});
    vecs.push_back('{1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 8'hC3});
    vecs.push_back('{1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'h66, 1'b0, 1'b1, 8'h99});
    vecs.push_back('{1'b0, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00});
    vecs.push_back('{1'b1, 1'b0, 8'hE7, 1'b1, 1'b1, 8'hE7});
    foreach (vecs[i]) begin
      set_rst(vecs[i].rst_n);
      out_control = vecs[i].oe_n;
      data = vecs[i].data;
      #2;
      if (vecs[i].edge_en) rise();
      check($sformatf("vec%0d", i), vecs[i].exp_drv, vecs[i].exp_out);
    end

    // ---------------- enable after ~1000 ns of free running capture ----------------
    out_control = 1'b1;
    data = 8'h00;
    for (int k = 0; k < 9; k++) begin
      data = data + 8'h01;
      #55;
      clk = ~clk;
      if (clk && rst_n) exp_q = data;
      #55;
    end
    if (clk) begin
      clk = 1'b0;
    end
    check("run_disabled", 1'b0, 8'h00);
    out_control = 1'b0;
    check("run_enable_shows_last", 1'b1, 8'h09);

    // ---------------- falling edge alone does nothing ----------------
    data = 8'h3C;
    #2;
    clk = 1'b1;
    exp_q = data;
    #5;
    data = 8'hC3;
    #2;
    clk = 1'b0;
    check("negedge_only", 1'b1, 8'h3C);
    rise();
    check("next_posedge", 1'b1, 8'hC3);

    // ---------------- async reset between edges ----------------
    data = 8'h7F;
    rise();
    check("pre_reset_7f", 1'b1, 8'h7F);
    set_rst(1'b0);
    check("async_reset_no_clk", 1'b1, 8'h00);
    set_rst(1'b1);
    check("after_release", 1'b1, 8'h00);
    data = 8'h11;
    rise();
    check("first_capture_after_reset", 1'b1, 8'h11);

    // ---------------- reset while disabled ----------------
    out_control = 1'b1;
    data = 8'h44;
    rise();
    set_rst(1'b0);
    check("reset_disabled_float", 1'b0, 8'h00);
    set_rst(1'b1);
    out_control = 1'b0;
    check("enable_after_reset_zero", 1'b1, 8'h00);
    data = 8'h22;
    rise();
    check("capture_after_reset_enable", 1'b1, 8'h22);

    // ---------------- enable toggling with no clock ----------------
    data = 8'h55;
    rise();
    data = 8'h00;
    out_control = 1'b0;
    check("toggle_on1", 1'b1, 8'h55);
    out_control = 1'b1;
    check("toggle_off", 1'b0, 8'h00);
    out_control = 1'b0;
    check("toggle_on2", 1'b1, 8'h55);

    // ---------------- randomized against the model ----------------
    for (int r = 0; r < 300; r++) begin
      int act;
      set_rst(($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1);
      out_control = $urandom_range(0, 1);
      data = W'($urandom);
      #2;
      act = $urandom_range(0, 3);
      if (act < 2) begin
        rise();
      end else if (act == 2) begin
        clk = 1'b1;
        if (rst_n) exp_q = data;
        #3;
        data = W'($urandom);
        #2;
        clk = 1'b0;
      end
      check($sformatf("rand%0d", r), !out_control, exp_q);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sn74ls374
